// File: rtl/data_memory_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port MIPS DataMemory.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration (default is fixed priority, port 0 first).
module data_memory_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  memWrite,
  output logic                  memRead,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] write_data,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic                  grant,
  output logic                  busy
);

  // state  | meaning
  // IDLE   | waiting for a request, arbitrates and latches the winner
  // ACCESS | drives memory for one cycle, captures read data at its end
  // RESP   | one-cycle ack pulse to the winner
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_grant;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata0;
  logic [DATA_WIDTH-1:0] r_rdata1;
  logic                  w_any_req;
  logic                  w_winner;
  logic                  w_start;

  assign w_any_req = req0 | req1;
  assign w_start   = (r_state == ST_IDLE) && w_any_req;

`ifdef ARB_ROUND_ROBIN_EN
  // r_last holds the port served most recently; it resets to 1 so port 0 goes first.
  logic r_last;

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_last <= 1'b1;
    else if (w_start)
      r_last <= w_winner;
  end

  assign w_winner = (req0 && req1) ? ~r_last : req1;
`else
  assign w_winner = ~req0 & req1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    memWrite    = 1'b0;
    memRead     = 1'b0;
    ack0        = 1'b0;
    ack1        = 1'b0;
    busy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req)
          w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        busy        = 1'b1;
        memWrite    = r_we;
        memRead     = ~r_we;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        busy        = 1'b1;
        ack0        = ~r_grant;
        ack1        = r_grant;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_grant  <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      if (w_start) begin
        r_grant <= w_winner;
        r_we    <= w_winner ? we1 : we0;
        r_addr  <= w_winner ? addr1 : addr0;
        r_wdata <= w_winner ? wdata1 : wdata0;
      end
      // Only the winner's read register moves; writes leave both untouched.
      if (r_state == ST_ACCESS && !r_we) begin
        if (r_grant)
          r_rdata1 <= read_data;
        else
          r_rdata0 <= read_data;
      end
    end
  end

  assign grant      = r_grant;
  assign Address    = r_addr;
  assign write_data = r_wdata;
  assign rdata0     = r_rdata0;
  assign rdata1     = r_rdata1;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a small word-addressed memory model behind it.
module tb_data_memory_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1;
  logic [31:0] rdata0, rdata1;
  logic        memWrite, memRead;
  logic [31:0] Address, write_data, read_data;
  logic        grant, busy;

  logic [31:0] mem [0:63];

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata0;
    logic [31:0] exp_rdata1;
  } vec_t;

  vec_t vecs [10];

  data_memory_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .memWrite(memWrite), .memRead(memRead), .Address(Address),
    .write_data(write_data), .read_data(read_data),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (memWrite) mem[Address[7:2]] <= write_data;
  assign read_data = mem[Address[7:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, " ack0"}, {31'd0, ack0}, 32'd0);
    chk({tag, " ack1"}, {31'd0, ack1}, 32'd0);
    chk({tag, " busy"}, {31'd0, busy}, 32'd0);
    chk({tag, " grant"}, {31'd0, grant}, 32'd0);
    chk({tag, " memWrite"}, {31'd0, memWrite}, 32'd0);
    chk({tag, " memRead"}, {31'd0, memRead}, 32'd0);
    chk({tag, " Address"}, Address, 32'd0);
    chk({tag, " write_data"}, write_data, 32'd0);
    chk({tag, " rdata0"}, rdata0, 32'd0);
    chk({tag, " rdata1"}, rdata1, 32'd0);
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("vec%0d", idx);
    @(negedge clk);
    req0 = ~v.port; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
    req1 = v.port;  we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
    @(negedge clk);
    chk({t, " access busy"}, {31'd0, busy}, 32'd1);
    chk({t, " access grant"}, {31'd0, grant}, {31'd0, v.port});
    chk({t, " access memWrite"}, {31'd0, memWrite}, {31'd0, v.we});
    chk({t, " access memRead"}, {31'd0, memRead}, {31'd0, ~v.we});
    chk({t, " access Address"}, Address, v.addr);
    if (v.we) chk({t, " access write_data"}, write_data, v.wdata);
    @(negedge clk);
    chk({t, " resp ack0"}, {31'd0, ack0}, {31'd0, ~v.port});
    chk({t, " resp ack1"}, {31'd0, ack1}, {31'd0, v.port});
    chk({t, " resp mem ctl"}, {30'd0, memWrite, memRead}, 32'd0);
    chk({t, " resp rdata0"}, rdata0, v.exp_rdata0);
    chk({t, " resp rdata1"}, rdata1, v.exp_rdata1);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk({t, " idle busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    logic exp_g;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;

    vecs[0] = '{1'b0, 1'b1, 32'h10,       32'hDEADBEEF, 32'h0,        32'h0};
    vecs[1] = '{1'b0, 1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b1, 1'b1, 32'h20,       32'h12345678, 32'hDEADBEEF, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 32'h20,       32'h0,        32'h12345678, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 32'h10,       32'h0,        32'h12345678, 32'hDEADBEEF};
    vecs[5] = '{1'b0, 1'b1, 32'h3C,       32'hA5A5A5A5, 32'h12345678, 32'hDEADBEEF};
    vecs[6] = '{1'b1, 1'b0, 32'h3C,       32'h0,        32'h12345678, 32'hA5A5A5A5};
    vecs[7] = '{1'b0, 1'b1, 32'hFFFFFFFC, 32'h0BADF00D, 32'h12345678, 32'hA5A5A5A5};
    vecs[8] = '{1'b0, 1'b0, 32'h3C,       32'h0,        32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[9] = '{1'b1, 1'b0, 32'hFFFFFFFC, 32'h0,        32'hA5A5A5A5, 32'h0BADF00D};

    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (3) @(negedge clk);
    chk_reset_values("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) apply_vec(vecs[i], i);

    // Both ports request continuously for six grants.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h20;
    for (int g = 0; g < 6; g++) begin
      cyc = 0;
      while (!(ack0 || ack1) && cyc < 10) begin
        @(negedge clk);
        cyc++;
      end
      if (cyc >= 10) begin
        chk($sformatf("contend grant%0d timeout", g), 32'd1, 32'd0);
      end else begin
`ifdef ARB_ROUND_ROBIN_EN
        exp_g = g[0];
`else
        exp_g = 1'b0;
`endif
        chk($sformatf("contend grant%0d", g), {31'd0, ack1}, {31'd0, exp_g});
        if (ack1) chk($sformatf("contend rdata1 %0d", g), rdata1, 32'h12345678);
        else      chk($sformatf("contend rdata0 %0d", g), rdata0, 32'hDEADBEEF);
        if (g == 5) begin
          req0 = 1'b0; req1 = 1'b0;
        end
        @(negedge clk);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);

    // Port 1 raises req during port 0's ACCESS cycle.
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    @(negedge clk);
    chk("late access grant", {31'd0, grant}, 32'd0);
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h20;
    @(negedge clk);
    chk("late ack0", {31'd0, ack0}, 32'd1);
    chk("late ack1 low", {31'd0, ack1}, 32'd0);
    req0 = 1'b0;
    @(negedge clk);
    chk("late idle busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("late p1 busy", {31'd0, busy}, 32'd1);
    chk("late p1 grant", {31'd0, grant}, 32'd1);
    chk("late p1 Address", Address, 32'h20);
    @(negedge clk);
    chk("late p1 ack1", {31'd0, ack1}, 32'd1);
    chk("late p1 rdata1", rdata1, 32'h12345678);
    req1 = 1'b0;
    @(negedge clk);

    // Reset pulled during ACCESS of a port 0 read.
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h3C;
    @(negedge clk);
    chk("rst access memRead", {31'd0, memRead}, 32'd1);
    rst_n = 1'b0; req0 = 1'b0;
    @(negedge clk);
    chk_reset_values("midrst");
    rst_n = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    @(negedge clk);
    chk("post-rst busy", {31'd0, busy}, 32'd1);
    chk("post-rst memRead", {31'd0, memRead}, 32'd1);
    chk("post-rst Address", Address, 32'h10);
    @(negedge clk);
    chk("post-rst ack0", {31'd0, ack0}, 32'd1);
    chk("post-rst rdata0", rdata0, 32'hDEADBEEF);
    req0 = 1'b0;
    @(negedge clk);
    chk("post-rst idle busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
